// File: rtl/except_ctrl.sv
// MEM-stage exception arbiter: picks one exception by fixed priority, hands it to CP0,
// and issues a one-cycle registered flush followed by a detection-blanking shadow window.
module except_ctrl #(
  parameter logic [31:0] EXC_VECTOR    = 32'h0000_0020,
  parameter int unsigned SHADOW_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] current_inst_addr_i,
  input  logic        is_in_delayslot_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_data_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] current_inst_addr_o,
  output logic        is_in_delayslot_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic [15:0] exc_count_o
);

  localparam logic [4:0]  CP0_STATUS = 5'd12;
  localparam logic [4:0]  CP0_CAUSE  = 5'd13;
  localparam logic [4:0]  CP0_EPC    = 5'd14;
  // Cause bits software may write: IP1..IP0 (9:8), IV (23), WP (22).
  localparam logic [31:0] CAUSE_WMASK = 32'h00C0_0300;

  localparam logic [31:0] CODE_NONE     = 32'h0000_0000;
  localparam logic [31:0] CODE_INT      = 32'h0000_0001;
  localparam logic [31:0] CODE_SYSCALL  = 32'h0000_0008;
  localparam logic [31:0] CODE_INVALID  = 32'h0000_000a;
  localparam logic [31:0] CODE_TRAP     = 32'h0000_000d;
  localparam logic [31:0] CODE_OVERFLOW = 32'h0000_000c;
  localparam logic [31:0] CODE_ERET     = 32'h0000_000e;

  localparam bit         HAS_SHADOW  = (SHADOW_CYCLES > 0);
  localparam logic [3:0] SHADOW_LOAD = HAS_SHADOW ? 4'(SHADOW_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_SHADOW
  } state_t;

  // ---------------------------------------------------------------- forwarding
  logic        status_wr;
  logic        cause_wr;
  logic        epc_wr;
  logic [31:0] status_fwd;
  logic [31:0] cause_fwd;
  logic [31:0] epc_fwd;

  assign status_wr  = wb_cp0_we_i && (wb_cp0_waddr_i == CP0_STATUS);
  assign cause_wr   = wb_cp0_we_i && (wb_cp0_waddr_i == CP0_CAUSE);
  assign epc_wr     = wb_cp0_we_i && (wb_cp0_waddr_i == CP0_EPC);
  assign status_fwd = status_wr ? wb_cp0_data_i : cp0_status_i;
  assign epc_fwd    = epc_wr ? wb_cp0_data_i : cp0_epc_i;

  // Hardware-owned Cause bits (pending IP7..IP2, ExcCode, BD) never come from an mtc0.
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_cause_fwd
      assign cause_fwd[gi] = (CAUSE_WMASK[gi] && cause_wr) ? wb_cp0_data_i[gi]
                                                          : cp0_cause_i[gi];
    end
  endgenerate

  // ---------------------------------------------------------------- detection
  logic        inst_valid;
  logic        int_pending;
  logic [31:0] exc_code;
  logic        exc_hit;

  assign inst_valid  = (current_inst_addr_i != 32'd0);
  assign int_pending = inst_valid
                    && ((cause_fwd[15:8] & status_fwd[15:8]) != 8'd0)
                    && !status_fwd[1]
                    && status_fwd[0];

  always_comb begin
    exc_code = CODE_NONE;
    if (inst_valid) begin
      if (int_pending)          exc_code = CODE_INT;
      else if (excepttype_i[8]) exc_code = CODE_SYSCALL;
      else if (excepttype_i[9]) exc_code = CODE_INVALID;
      else if (excepttype_i[10]) exc_code = CODE_TRAP;
      else if (excepttype_i[11]) exc_code = CODE_OVERFLOW;
      else if (excepttype_i[12]) exc_code = CODE_ERET;
    end
  end

  assign exc_hit = (exc_code != CODE_NONE);

  // ---------------------------------------------------------------- control FSM
  state_t      state_reg;
  logic [3:0]  shadow_cnt_reg;
  logic [31:0] excepttype_reg;
  logic [31:0] inst_addr_reg;
  logic        delayslot_reg;
  logic        flush_reg;
  logic [31:0] new_pc_reg;
  logic [15:0] exc_count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      shadow_cnt_reg <= 4'd0;
      excepttype_reg <= CODE_NONE;
      inst_addr_reg  <= 32'd0;
      delayslot_reg  <= 1'b0;
      flush_reg      <= 1'b0;
      new_pc_reg     <= 32'd0;
      exc_count_reg  <= 16'd0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (exc_hit) begin
            excepttype_reg <= exc_code;
            inst_addr_reg  <= current_inst_addr_i;
            delayslot_reg  <= is_in_delayslot_i;
            flush_reg      <= 1'b1;
            new_pc_reg     <= (exc_code == CODE_ERET) ? epc_fwd : EXC_VECTOR;
            exc_count_reg  <= (exc_count_reg == 16'hFFFF) ? exc_count_reg
                                                          : exc_count_reg + 16'd1;
            state_reg      <= ST_FLUSH;
          end
        end
        // The instruction now in MEM is younger than the excepting one and is squashed.
        ST_FLUSH: begin
          excepttype_reg <= CODE_NONE;
          delayslot_reg  <= 1'b0;
          flush_reg      <= 1'b0;
          new_pc_reg     <= 32'd0;
          if (HAS_SHADOW) begin
            shadow_cnt_reg <= SHADOW_LOAD;
            state_reg      <= ST_SHADOW;
          end else begin
            state_reg      <= ST_IDLE;
          end
        end
        ST_SHADOW: begin
          if (shadow_cnt_reg == 4'd0) begin
            state_reg <= ST_IDLE;
          end else begin
            shadow_cnt_reg <= shadow_cnt_reg - 4'd1;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign excepttype_o        = excepttype_reg;
  assign current_inst_addr_o = inst_addr_reg;
  assign is_in_delayslot_o   = delayslot_reg;
  assign flush_o             = flush_reg;
  assign new_pc_o            = new_pc_reg;
  assign exc_count_o         = exc_count_reg;

  // Register bits this block has no use for.
  logic unused_bits;
  assign unused_bits = &{1'b0, excepttype_i[31:13], excepttype_i[7:0],
                         status_fwd[31:16], status_fwd[7:2],
                         cause_fwd[31:16], cause_fwd[7:0]};

endmodule

// File: tb/tb_except_ctrl.sv
// Directed bench for except_ctrl: priority, forwarding, shadow blanking, saturation, reset abort.
module tb_except_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] excepttype_i;
  logic [31:0] current_inst_addr_i;
  logic        is_in_delayslot_i;
  logic [31:0] cp0_status_i;
  logic [31:0] cp0_cause_i;
  logic [31:0] cp0_epc_i;
  logic        wb_cp0_we_i;
  logic [4:0]  wb_cp0_waddr_i;
  logic [31:0] wb_cp0_data_i;
  logic [31:0] excepttype_o;
  logic [31:0] current_inst_addr_o;
  logic        is_in_delayslot_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic [15:0] exc_count_o;

  int passed = 0;
  int total  = 0;
  int flush_seen = 0;

  always #5 clk = ~clk;

  except_ctrl #(.EXC_VECTOR(32'h0000_0020), .SHADOW_CYCLES(2)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .excepttype_i        (excepttype_i),
    .current_inst_addr_i (current_inst_addr_i),
    .is_in_delayslot_i   (is_in_delayslot_i),
    .cp0_status_i        (cp0_status_i),
    .cp0_cause_i         (cp0_cause_i),
    .cp0_epc_i           (cp0_epc_i),
    .wb_cp0_we_i         (wb_cp0_we_i),
    .wb_cp0_waddr_i      (wb_cp0_waddr_i),
    .wb_cp0_data_i       (wb_cp0_data_i),
    .excepttype_o        (excepttype_o),
    .current_inst_addr_o (current_inst_addr_o),
    .is_in_delayslot_o   (is_in_delayslot_o),
    .flush_o             (flush_o),
    .new_pc_o            (new_pc_o),
    .exc_count_o         (exc_count_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    excepttype_i        = 32'd0;
    current_inst_addr_i = 32'd0;
    is_in_delayslot_i   = 1'b0;
    cp0_status_i        = 32'd0;
    cp0_cause_i         = 32'd0;
    cp0_epc_i           = 32'd0;
    wb_cp0_we_i         = 1'b0;
    wb_cp0_waddr_i      = 5'd0;
    wb_cp0_data_i       = 32'd0;
  endtask

  // Called in the FLUSH cycle: drop stimulus and walk through the two shadow cycles to IDLE.
  task automatic drain();
    clear_inputs();
    repeat (3) tick();
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    chk("reset excepttype", excepttype_o, 32'h0);
    chk("reset flush", {31'd0, flush_o}, 32'h0);
    chk("reset new_pc", new_pc_o, 32'h0);
    chk("reset addr", current_inst_addr_o, 32'h0);
    chk("reset delayslot", {31'd0, is_in_delayslot_o}, 32'h0);
    chk("reset count", {16'd0, exc_count_o}, 32'h0);

    // Syscall, held through the shadow window to prove it is blanked.
    excepttype_i = 32'h100; current_inst_addr_i = 32'h40;
    tick();
    $display("syscall flush: code=%h pc=%h addr=%h cnt=%0d", excepttype_o, new_pc_o, current_inst_addr_o, exc_count_o);
    chk("sys code", excepttype_o, 32'h8);
    chk("sys flush", {31'd0, flush_o}, 32'h1);
    chk("sys new_pc", new_pc_o, 32'h20);
    chk("sys addr", current_inst_addr_o, 32'h40);
    chk("sys count", {16'd0, exc_count_o}, 32'h1);
    tick();
    chk("shadow1 flush", {31'd0, flush_o}, 32'h0);
    chk("shadow1 code", excepttype_o, 32'h0);
    chk("shadow1 new_pc", new_pc_o, 32'h0);
    chk("shadow1 addr held", current_inst_addr_o, 32'h40);
    tick();
    chk("shadow2 flush", {31'd0, flush_o}, 32'h0);
    clear_inputs();
    tick();
    chk("idle after shadow", {31'd0, flush_o}, 32'h0);

    // ERET with EPC forwarded from WB.
    excepttype_i = 32'h1000; current_inst_addr_i = 32'h44; cp0_epc_i = 32'h100;
    wb_cp0_we_i = 1'b1; wb_cp0_waddr_i = 5'd14; wb_cp0_data_i = 32'h200;
    tick();
    $display("eret flush: code=%h pc=%h", excepttype_o, new_pc_o);
    chk("eret code", excepttype_o, 32'he);
    chk("eret new_pc", new_pc_o, 32'h200);
    chk("eret count", {16'd0, exc_count_o}, 32'h2);
    drain();

    // Interrupt beats syscall and overflow; delay-slot flag propagates.
    excepttype_i = 32'h900; current_inst_addr_i = 32'h48; is_in_delayslot_i = 1'b1;
    cp0_status_i = 32'h401; cp0_cause_i = 32'h400;
    tick();
    $display("int flush: code=%h ds=%b addr=%h", excepttype_o, is_in_delayslot_o, current_inst_addr_o);
    chk("int code", excepttype_o, 32'h1);
    chk("int delayslot", {31'd0, is_in_delayslot_o}, 32'h1);
    chk("int addr", current_inst_addr_o, 32'h48);
    chk("int new_pc", new_pc_o, 32'h20);
    tick();
    chk("shadow delayslot", {31'd0, is_in_delayslot_o}, 32'h0);
    clear_inputs();
    repeat (2) tick();

    // EXL set masks the interrupt.
    cp0_status_i = 32'h403; cp0_cause_i = 32'h400; current_inst_addr_i = 32'h4c;
    tick();
    $display("exl masked: flush=%b", flush_o);
    chk("exl flush", {31'd0, flush_o}, 32'h0);
    chk("exl code", excepttype_o, 32'h0);

    // Bubble raises nothing, even with syscall flags and a live interrupt.
    cp0_status_i = 32'h401; current_inst_addr_i = 32'h0; excepttype_i = 32'h100;
    tick();
    $display("bubble: flush=%b cnt=%0d", flush_o, exc_count_o);
    chk("bubble flush", {31'd0, flush_o}, 32'h0);
    chk("bubble count", {16'd0, exc_count_o}, 32'h3);

    // Cause forwarding: bit 10 is not software-writable, bit 8 is.
    clear_inputs();
    cp0_status_i = 32'h501; current_inst_addr_i = 32'h50;
    wb_cp0_we_i = 1'b1; wb_cp0_waddr_i = 5'd13; wb_cp0_data_i = 32'h400;
    tick();
    chk("cause ip2 not fwd", {31'd0, flush_o}, 32'h0);
    wb_cp0_data_i = 32'h100; cp0_status_i = 32'h101;
    tick();
    $display("cause fwd int: code=%h", excepttype_o);
    chk("cause ip0 fwd", excepttype_o, 32'h1);
    chk("cause count", {16'd0, exc_count_o}, 32'h4);
    drain();

    // Overflow held for 5 cycles: flushes on cycles 1 and 5 only.
    excepttype_i = 32'h800; current_inst_addr_i = 32'h60;
    flush_seen = 0;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (flush_o) flush_seen++;
      if (c == 5) clear_inputs();
      $display("overflow cycle %0d: flush=%b code=%h", c, flush_o, excepttype_o);
      chk($sformatf("ovf cycle %0d flush", c), {31'd0, flush_o},
          (c == 1 || c == 5) ? 32'h1 : 32'h0);
    end
    chk("ovf flush total", flush_seen, 32'd2);
    chk("ovf count", {16'd0, exc_count_o}, 32'h6);
    repeat (2) tick();

    // Saturation: preset counter just below the top.
    force dut.exc_count_reg = 16'hFFFE;
    #1;
    release dut.exc_count_reg;
    chk("preset count", {16'd0, exc_count_o}, 32'hFFFE);
    excepttype_i = 32'h400; current_inst_addr_i = 32'h70;
    tick();
    chk("trap code", excepttype_o, 32'hd);
    chk("count to max", {16'd0, exc_count_o}, 32'hFFFF);
    drain();
    excepttype_i = 32'h200; current_inst_addr_i = 32'h74;
    tick();
    $display("saturate: code=%h cnt=%h", excepttype_o, exc_count_o);
    chk("invalid code", excepttype_o, 32'ha);
    chk("count saturated", {16'd0, exc_count_o}, 32'hFFFF);
    drain();

    // Reset during the flush cycle aborts, then a fresh syscall is taken.
    excepttype_i = 32'h100; current_inst_addr_i = 32'h80;
    tick();
    chk("pre-reset flush", {31'd0, flush_o}, 32'h1);
    rst = 1'b1;
    tick();
    $display("reset mid-flush: flush=%b code=%h cnt=%0d", flush_o, excepttype_o, exc_count_o);
    chk("rst flush", {31'd0, flush_o}, 32'h0);
    chk("rst code", excepttype_o, 32'h0);
    chk("rst addr", current_inst_addr_o, 32'h0);
    chk("rst count", {16'd0, exc_count_o}, 32'h0);
    rst = 1'b0; current_inst_addr_i = 32'h84;
    tick();
    $display("post-reset syscall: flush=%b code=%h addr=%h", flush_o, excepttype_o, current_inst_addr_o);
    chk("post-rst flush", {31'd0, flush_o}, 32'h1);
    chk("post-rst code", excepttype_o, 32'h8);
    chk("post-rst addr", current_inst_addr_o, 32'h84);
    chk("post-rst count", {16'd0, exc_count_o}, 32'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
